thirty_two_bit_multiplier: RTL and testbench
============================================

# thirty_two_bit_multiplier

Registered signed 32×32→64 multiplier for the LEGv8 datapath's multiply unit. Takes two 64-bit register-file operands, multiplies their low 32-bit halves as two's-complement values, and presents the full 64-bit signed product one clock later. Fully pipelined: a new operand pair may be presented every cycle.

## Interface
- Parameters: none; widths come from the shared package (`MULT_IN_W`=32, `MULT_OUT_W`=64, `REG_W`=64).
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `a` input, 64 bits: multiplicand; only `a[31:0]` is used.
- `b` input, 64 bits: multiplier; only `b[31:0]` is used.
- `product` output, 64 bits: registered signed product.
- `operand_err` output, 1 bit: present only when `MULT_OPERAND_CHECK_EN` is defined.

## Operation
- The block computes `$signed(a[31:0]) * $signed(b[31:0])`, and the result is exact in 64 bits.
- No overflow is possible: the range is −2^62+2^31 … 2^62.
- `a[63:32]` and `b[63:32]` are ignored for the arithmetic.
- The core is a radix-4 Booth encoder: 17 partial products, each sign-extended to 64 bits.
- The partial products are summed by a carry-save (3:2 compressor) tree, then one final 64-bit carry-propagate add.
- The core uses no `*` operator.
- Corner cases must be exact:
  - (−2^31)×(−2^31) = 0x4000_0000_0000_0000.
  - (−2^31)×1 = 0xFFFF_FFFF_8000_0000.
  - Any operand of 0 gives 0.

## Timing
- Latency is 1 cycle.
- The core is combinational from `a`/`b`; `product` is captured on every rising `clk`.
- `product` is stable from just after that edge until the next edge.
- Throughput is one result per cycle. There is no handshake, no stall and no valid signal.
- While `rst_n`=0:
  - `product`=0 immediately (asynchronous), and `operand_err`=0.
  - The register holds 0 regardless of `clk`.
- Reset release: the first rising edge after `rst_n` returns high captures the current operands.
- Reset asserted mid-stream: the in-flight result is discarded; there is no recovery of it.
- Inputs are sampled only at the rising edge. Input changes between edges do not affect `product`.

## Configuration
- Macro: `MULT_OPERAND_CHECK_EN`.
- Defined:
  - Adds the `operand_err` output, registered with the same 1-cycle latency as `product`.
  - `operand_err`=1 when `a[63:32]` is not all copies of `a[31]`, or `b[63:32]` is not all copies of `b[31]`.
  - `product` is unaffected by the check.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- Package `mult_pkg`:
  - Width constants `MULT_IN_W`, `MULT_OUT_W`, `REG_W`.
  - Booth digit typedef: 3-bit encoding of {0, +1, +2, −1, −2}.
  - Function `booth_sel(triplet)` returning that digit.
- Sub-module `booth_pp_gen`, instantiated once: takes the 32-bit multiplicand and the 32-bit multiplier and outputs 17 sign-extended, shifted 64-bit partial products.
- Top level: CSA tree, final adder, output register(s), optional operand check.

## Test plan
- Reset: hold `rst_n`=0 with a=5, b=7 → `product`=0 throughout. Release, then after 1 edge → `product`=35.
- Squares sweep: a=b={32'h0, i} for i=0…999, one pair per cycle → `product`=i² zero-upper; e.g. i=999 → 998001.
- Positive×negative sweep: a={32'h0, i}, b={32'hFFFF_FFFF, ~i} (= −(i+1)) for i=1…999 → `product`=−i(i+1) sign-extended. Examples:
  - i=1 → 0xFFFF_FFFF_FFFF_FFFE.
  - i=999 → −999000.
- Extremes:
  - a=b=0x8000_0000 (low halves) → 0x4000_0000_0000_0000.
  - a=0x7FFF_FFFF, b=0x7FFF_FFFF → 0x3FFF_FFFF_0000_0001.
  - a=0xFFFF_FFFF, b=0xFFFF_FFFF → 1.
- Upper-half independence: a=0xDEAD_BEEF_0000_0003, b=0x1234_5678_FFFF_FFFE → `product`=−6 (0xFFFF_FFFF_FFFF_FFFA). With `MULT_OPERAND_CHECK_EN` defined, `operand_err`=1 in the same cycle as that product.
- Back-to-back and mid-stream reset: change operands every cycle → each `product` matches the previous cycle's operands. Assert `rst_n` asynchronously between edges → `product` goes to 0 immediately, before the next edge.

Source files
------------

// File: rtl/thirty_two_bit_multiplier_pkg.sv
// Shared widths, Booth digit encoding and carry-save helper for the LEGv8 multiply unit.
// Used by booth_pp_gen and thirty_two_bit_multiplier.
package mult_pkg;

  localparam int MULT_IN_W  = 32;
  localparam int MULT_OUT_W = 64;
  localparam int REG_W      = 64;
  // One extra digit absorbs the sign extension of the multiplier.
  localparam int NUM_PP     = MULT_IN_W / 2 + 1;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'b000,
    BOOTH_P1   = 3'b001,
    BOOTH_P2   = 3'b010,
    BOOTH_M1   = 3'b101,
    BOOTH_M2   = 3'b110
  } booth_digit_t;

  typedef struct packed {
    logic [MULT_OUT_W-1:0] sum;
    logic [MULT_OUT_W-1:0] carry;
  } csa_t;

  // Triplet is {m[2j+1], m[2j], m[2j-1]}.
  function automatic booth_digit_t booth_sel(input logic [2:0] triplet);
    booth_digit_t d;
    case (triplet)
      3'b001, 3'b010: d = BOOTH_P1;
      3'b011:         d = BOOTH_P2;
      3'b100:         d = BOOTH_M2;
      3'b101, 3'b110: d = BOOTH_M1;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

  function automatic csa_t csa3(input logic [MULT_OUT_W-1:0] x,
                                input logic [MULT_OUT_W-1:0] y,
                                input logic [MULT_OUT_W-1:0] z);
    csa_t r;
    r.sum   = x ^ y ^ z;
    r.carry = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/thirty_two_bit_multiplier_booth_pp_gen.sv
// Radix-4 Booth partial-product generator: 17 sign-extended, pre-shifted 64-bit rows.
// Row j occupies o_pp[j*64 +: 64].
module booth_pp_gen
  import mult_pkg::*;
(
  input  logic [MULT_IN_W-1:0]         i_mcand,
  input  logic [MULT_IN_W-1:0]         i_mplier,
  output logic [NUM_PP*MULT_OUT_W-1:0] o_pp
);

  logic [MULT_OUT_W-1:0] w_mcand_ext;
  logic [2*NUM_PP:0]     w_mplier_ext;
  logic [MULT_OUT_W-1:0] w_term;

  assign w_mcand_ext  = {{(MULT_OUT_W-MULT_IN_W){i_mcand[MULT_IN_W-1]}}, i_mcand};
  assign w_mplier_ext = {{2{i_mplier[MULT_IN_W-1]}}, i_mplier, 1'b0};

  // Negation wraps mod 2^64; the rows still sum to the exact product.
  always_comb begin
    o_pp   = '0;
    w_term = '0;
    for (int unsigned j = 0; j < NUM_PP; j++) begin
      case (booth_sel(w_mplier_ext[2*j +: 3]))
        BOOTH_P1: w_term = w_mcand_ext;
        BOOTH_P2: w_term = w_mcand_ext << 1;
        BOOTH_M1: w_term = ~w_mcand_ext + 64'd1;
        BOOTH_M2: w_term = ~(w_mcand_ext << 1) + 64'd1;
        default:  w_term = '0;
      endcase
      o_pp[j*MULT_OUT_W +: MULT_OUT_W] = w_term << (2*j);
    end
  end

endmodule

// File: rtl/thirty_two_bit_multiplier.sv
// Registered signed 32x32->64 multiplier: Booth rows, 3:2 CSA tree, final CPA, output register.
// Optional MULT_OPERAND_CHECK_EN adds operand_err for non-sign-extended upper operand halves.
module thirty_two_bit_multiplier
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_W-1:0]      a,
  input  logic [REG_W-1:0]      b,
  output logic [MULT_OUT_W-1:0] product
`ifdef MULT_OPERAND_CHECK_EN
  ,
  output logic                  operand_err
`endif
);

  logic [NUM_PP*MULT_OUT_W-1:0] w_pp;
  logic [MULT_OUT_W-1:0]        w_s0 [17];
  logic [MULT_OUT_W-1:0]        w_s1 [12];
  logic [MULT_OUT_W-1:0]        w_s2 [8];
  logic [MULT_OUT_W-1:0]        w_s3 [6];
  logic [MULT_OUT_W-1:0]        w_s4 [4];
  logic [MULT_OUT_W-1:0]        w_s5 [3];
  logic [MULT_OUT_W-1:0]        w_s6 [2];
  logic [MULT_OUT_W-1:0]        w_sum;
  logic [MULT_OUT_W-1:0]        r_product;

  booth_pp_gen u_booth_pp_gen (
    .i_mcand  (a[MULT_IN_W-1:0]),
    .i_mplier (b[MULT_IN_W-1:0]),
    .o_pp     (w_pp)
  );

  // Wallace-style reduction 17->12->8->6->4->3->2; leftover rows pass through each level.
  always_comb begin
    for (int unsigned i = 0; i < 17; i++) w_s0[i] = w_pp[i*MULT_OUT_W +: MULT_OUT_W];

    for (int unsigned g = 0; g < 5; g++)
      {w_s1[2*g], w_s1[2*g+1]} = csa3(w_s0[3*g], w_s0[3*g+1], w_s0[3*g+2]);
    w_s1[10] = w_s0[15];
    w_s1[11] = w_s0[16];

    for (int unsigned g = 0; g < 4; g++)
      {w_s2[2*g], w_s2[2*g+1]} = csa3(w_s1[3*g], w_s1[3*g+1], w_s1[3*g+2]);

    for (int unsigned g = 0; g < 2; g++)
      {w_s3[2*g], w_s3[2*g+1]} = csa3(w_s2[3*g], w_s2[3*g+1], w_s2[3*g+2]);
    w_s3[4] = w_s2[6];
    w_s3[5] = w_s2[7];

    for (int unsigned g = 0; g < 2; g++)
      {w_s4[2*g], w_s4[2*g+1]} = csa3(w_s3[3*g], w_s3[3*g+1], w_s3[3*g+2]);

    {w_s5[0], w_s5[1]} = csa3(w_s4[0], w_s4[1], w_s4[2]);
    w_s5[2] = w_s4[3];

    {w_s6[0], w_s6[1]} = csa3(w_s5[0], w_s5[1], w_s5[2]);
  end

  assign w_sum = w_s6[0] + w_s6[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_product <= '0;
    else        r_product <= w_sum;
  end

  assign product = r_product;

`ifdef MULT_OPERAND_CHECK_EN
  logic w_operand_err;
  logic r_operand_err;

  assign w_operand_err = (a[REG_W-1:MULT_IN_W] != {(REG_W-MULT_IN_W){a[MULT_IN_W-1]}}) ||
                         (b[REG_W-1:MULT_IN_W] != {(REG_W-MULT_IN_W){b[MULT_IN_W-1]}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_operand_err <= 1'b0;
    else        r_operand_err <= w_operand_err;
  end

  assign operand_err = r_operand_err;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^{a[REG_W-1:MULT_IN_W], b[REG_W-1:MULT_IN_W]};
`endif

endmodule

// File: tb/tb_thirty_two_bit_multiplier.sv
// Directed self-checking bench for thirty_two_bit_multiplier.
// Honors MULT_OPERAND_CHECK_EN when the design is built with it.
module tb_thirty_two_bit_multiplier;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] product;
`ifdef MULT_OPERAND_CHECK_EN
  logic        operand_err;
`endif

  int checks;
  int errors;

  thirty_two_bit_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .product (product)
`ifdef MULT_OPERAND_CHECK_EN
    ,
    .operand_err (operand_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a = 64'd5;
    b = 64'd7;
    #1;
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", product, 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (product !== 64'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, product, 64'd0);
      end
`ifdef MULT_OPERAND_CHECK_EN
      checks++;
      if (operand_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_err got=%b exp=0", operand_err);
      end
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (product !== 64'd35) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", product, 64'd35);
    end
  endtask

  task automatic test_squares();
    logic [63:0] exp;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a = {32'h0, 32'(i)};
      b = {32'h0, 32'(i)};
      exp = 64'(i) * 64'(i);
      @(posedge clk); #1;
      checks++;
      if (product !== exp) begin
        errors++;
        $display("FAIL squares i=%0d got=%h exp=%h", i, product, exp);
      end
    end
    checks++;
    if (product !== 64'd998001) begin
      errors++;
      $display("FAIL squares_999 got=%h exp=%h", product, 64'd998001);
    end
  endtask

  task automatic test_pos_neg();
    logic [63:0] exp;
    logic [31:0] iv;
    for (int i = 1; i < 1000; i++) begin
      @(negedge clk);
      iv = 32'(i);
      a = {32'h0, iv};
      b = {32'hFFFF_FFFF, ~iv};
      exp = -(64'(i) * 64'(i + 1));
      @(posedge clk); #1;
      checks++;
      if (product !== exp) begin
        errors++;
        $display("FAIL posneg i=%0d got=%h exp=%h", i, product, exp);
      end
      if (i == 1) begin
        checks++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFFE) begin
          errors++;
          $display("FAIL posneg_1 got=%h exp=%h", product, 64'hFFFF_FFFF_FFFF_FFFE);
        end
      end
    end
    checks++;
    if (product !== 64'hFFFF_FFFF_FFF0_C1A8) begin
      errors++;
      $display("FAIL posneg_999 got=%h exp=%h", product, 64'hFFFF_FFFF_FFF0_C1A8);
    end
  endtask

  task automatic test_extremes();
    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic [63:0] ve [6];
    va[0] = 64'h0000_0000_8000_0000; vb[0] = 64'h0000_0000_8000_0000; ve[0] = 64'h4000_0000_0000_0000;
    va[1] = 64'h0000_0000_7FFF_FFFF; vb[1] = 64'h0000_0000_7FFF_FFFF; ve[1] = 64'h3FFF_FFFF_0000_0001;
    va[2] = 64'h0000_0000_FFFF_FFFF; vb[2] = 64'h0000_0000_FFFF_FFFF; ve[2] = 64'h0000_0000_0000_0001;
    va[3] = 64'h0000_0000_8000_0000; vb[3] = 64'h0000_0000_0000_0001; ve[3] = 64'hFFFF_FFFF_8000_0000;
    va[4] = 64'h0000_0000_8000_0000; vb[4] = 64'h0000_0000_0000_0000; ve[4] = 64'h0;
    va[5] = 64'h0000_0000_0000_0000; vb[5] = 64'h0000_0000_7FFF_FFFF; ve[5] = 64'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = va[k];
      b = vb[k];
      @(posedge clk); #1;
      checks++;
      if (product !== ve[k]) begin
        errors++;
        $display("FAIL extreme k=%0d got=%h exp=%h", k, product, ve[k]);
      end
    end
  endtask

  task automatic test_upper_half();
    @(negedge clk);
    a = 64'hDEAD_BEEF_0000_0003;
    b = 64'h1234_5678_FFFF_FFFE;
    @(posedge clk); #1;
    checks++;
    if (product !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++;
      $display("FAIL upper_half got=%h exp=%h", product, 64'hFFFF_FFFF_FFFF_FFFA);
    end
`ifdef MULT_OPERAND_CHECK_EN
    checks++;
    if (operand_err !== 1'b1) begin
      errors++;
      $display("FAIL upper_half_err got=%b exp=1", operand_err);
    end
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFD;
    b = 64'h0000_0000_0000_0002;
    @(posedge clk); #1;
    checks++;
    if (operand_err !== 1'b0) begin
      errors++;
      $display("FAIL clean_err got=%b exp=0", operand_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [63:0] va [7];
    logic [63:0] vb [7];
    logic [63:0] ve [7];
    va[0] = 64'd3;                   vb[0] = 64'd4;                   ve[0] = 64'd12;
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd5;                   ve[1] = 64'hFFFF_FFFF_FFFF_FFFB;
    va[2] = 64'h0000_0000_0001_0000; vb[2] = 64'h0000_0000_0001_0000; ve[2] = 64'h0000_0001_0000_0000;
    va[3] = 64'h0000_0000_8000_0000; vb[3] = 64'd1;                   ve[3] = 64'hFFFF_FFFF_8000_0000;
    va[4] = 64'h0000_0000_1234_5678; vb[4] = 64'd0;                   ve[4] = 64'd0;
    va[5] = 64'hFFFF_FFFF_FFFF_FFFD; vb[5] = 64'hFFFF_FFFF_FFFF_FFF9; ve[5] = 64'd21;
    va[6] = 64'h0000_0000_7FFF_FFFF; vb[6] = 64'hFFFF_FFFF_FFFF_FFFF; ve[6] = 64'hFFFF_FFFF_8000_0001;
    @(negedge clk);
    a = va[0];
    b = vb[0];
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      checks++;
      if (product !== ve[k]) begin
        errors++;
        $display("FAIL b2b k=%0d got=%h exp=%h", k, product, ve[k]);
      end
      a = 64'h0000_0000_0000_0009;
      b = 64'h0000_0000_0000_0009;
      #2;
      checks++;
      if (product !== ve[k]) begin
        errors++;
        $display("FAIL b2b_stable k=%0d got=%h exp=%h", k, product, ve[k]);
      end
      if (k < 6) begin
        a = va[k+1];
        b = vb[k+1];
      end
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    a = 64'd100;
    b = 64'd200;
    @(posedge clk); #1;
    checks++;
    if (product !== 64'd20000) begin
      errors++;
      $display("FAIL pre_reset got=%h exp=%h", product, 64'd20000);
    end
    a = 64'd11;
    b = 64'd13;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_async got=%h exp=%h", product, 64'd0);
    end
    @(posedge clk); #1;
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_hold got=%h exp=%h", product, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (product !== 64'd143) begin
      errors++;
      $display("FAIL mid_reset_release got=%h exp=%h", product, 64'd143);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_squares();
    test_pos_neg();
    test_extremes();
    test_upper_half();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
